// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush control unit:
// FSM encoding, default parameters, bubble values and the operand-match helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int CNT_W_DEF        = 32;
    localparam int FLUSH_W          = 4;

    // Pipeline registers load these when bubbled (addi x0, x0, 0 and no writeback).
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic        NOP_WB_WEN = 1'b0;

    localparam int N_PERF     = 2;
    localparam int PERF_STALL = 0;
    localparam int PERF_FLUSH = 1;

    function automatic logic reg_match(input logic [4:0] rs, input logic used,
                                       input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_flush_timer.sv
// Load/decrement/hold counter that tracks the remaining flush window.
// "active" is high while cycles remain, "last" on the final one.
module pipe_flush_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int W = FLUSH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         active,
    output logic         last
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Neither load nor dec means hold, which is how a memory stall freezes the window.
    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    assign active = (cnt_reg != '0);
    assign last   = (cnt_reg == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: load-use stalls, redirect flush window, memory-busy
// freeze, and saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       decode_i_rs1,
    input  logic [4:0]       decode_i_rs2,
    input  logic             decode_i_rs1_used,
    input  logic             decode_i_rs2_used,
    input  logic [4:0]       regE_i_wb_rd,
    input  logic             regE_i_wb_reg_wen,
    input  logic             regE_i_is_load,
    input  logic             execute_i_need_jump,
    input  logic             mem_i_busy,
    output logic             ctrl_o_regF_stall,
    output logic             ctrl_o_regD_stall,
    output logic             ctrl_o_regD_bubble,
    output logic             ctrl_o_regE_stall,
    output logic             ctrl_o_regE_bubble,
    output logic             ctrl_o_regM_bubble,
    output logic [CNT_W-1:0] ctrl_o_stall_cnt,
    output logic [CNT_W-1:0] ctrl_o_flush_cnt
);

    state_t state_reg;
    state_t state_next;

    logic lu;
    logic f_stall, d_stall, d_bubble, e_stall, e_bubble, m_bubble;
    logic flush_load, flush_dec, flush_active, flush_last, flush_accept;
    logic [N_PERF-1:0] perf_inc;

    assign lu = regE_i_is_load && regE_i_wb_reg_wen && (regE_i_wb_rd != 5'd0) &&
                (reg_match(decode_i_rs1, decode_i_rs1_used, regE_i_wb_rd) ||
                 reg_match(decode_i_rs2, decode_i_rs2_used, regE_i_wb_rd));

    pipe_flush_timer #(.W(FLUSH_W)) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (flush_load),
        .load_val (FLUSH_W'(FLUSH_CYCLES - 1)),
        .dec      (flush_dec),
        .active   (flush_active),
        .last     (flush_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        f_stall      = 1'b0;
        d_stall      = 1'b0;
        d_bubble     = 1'b0;
        e_stall      = 1'b0;
        e_bubble     = 1'b0;
        m_bubble     = 1'b0;
        flush_load   = 1'b0;
        flush_dec    = 1'b0;
        flush_accept = 1'b0;
        if (mem_i_busy) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_bubble = 1'b1;
        end else if (execute_i_need_jump) begin
            d_bubble     = 1'b1;
            e_bubble     = 1'b1;
            flush_load   = 1'b1;
            flush_accept = 1'b1;
            state_next   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if ((state_reg == ST_FLUSH) && flush_active) begin
            // D still holds a wrong-path instruction, so its operands are irrelevant.
            d_bubble  = 1'b1;
            flush_dec = 1'b1;
            if (flush_last) begin
                state_next = ST_RUN;
            end
        end else if (lu) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
        end
    end

    assign ctrl_o_regF_stall  = rst && f_stall;
    assign ctrl_o_regD_stall  = rst && d_stall;
    assign ctrl_o_regD_bubble = rst && d_bubble;
    assign ctrl_o_regE_stall  = rst && e_stall;
    assign ctrl_o_regE_bubble = rst && e_bubble;
    assign ctrl_o_regM_bubble = rst && m_bubble;

    assign perf_inc[PERF_STALL] = ctrl_o_regF_stall;
    assign perf_inc[PERF_FLUSH] = flush_accept;

    generate
        for (genvar gi = 0; gi < N_PERF; gi++) begin : g_perf
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign ctrl_o_stall_cnt = g_perf[PERF_STALL].cnt_reg;
    assign ctrl_o_flush_cnt = g_perf[PERF_FLUSH].cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two configurations (FLUSH_CYCLES=2/CNT_W=32 and
// FLUSH_CYCLES=1/CNT_W=4) share one stimulus stream and a behavioural model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, wb_rd;
    logic       rs1_used, rs2_used, wb_wen, is_load, need_jump, busy;

    logic       fs_a, ds_a, db_a, es_a, eb_a, mb_a;
    logic       fs_b, ds_b, db_b, es_b, eb_b, mb_b;
    logic [31:0] scnt_a, fcnt_a;
    logic [3:0]  scnt_b, fcnt_b;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .decode_i_rs1(rs1), .decode_i_rs2(rs2),
        .decode_i_rs1_used(rs1_used), .decode_i_rs2_used(rs2_used),
        .regE_i_wb_rd(wb_rd), .regE_i_wb_reg_wen(wb_wen), .regE_i_is_load(is_load),
        .execute_i_need_jump(need_jump), .mem_i_busy(busy),
        .ctrl_o_regF_stall(fs_a), .ctrl_o_regD_stall(ds_a), .ctrl_o_regD_bubble(db_a),
        .ctrl_o_regE_stall(es_a), .ctrl_o_regE_bubble(eb_a), .ctrl_o_regM_bubble(mb_a),
        .ctrl_o_stall_cnt(scnt_a), .ctrl_o_flush_cnt(fcnt_a)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .decode_i_rs1(rs1), .decode_i_rs2(rs2),
        .decode_i_rs1_used(rs1_used), .decode_i_rs2_used(rs2_used),
        .regE_i_wb_rd(wb_rd), .regE_i_wb_reg_wen(wb_wen), .regE_i_is_load(is_load),
        .execute_i_need_jump(need_jump), .mem_i_busy(busy),
        .ctrl_o_regF_stall(fs_b), .ctrl_o_regD_stall(ds_b), .ctrl_o_regD_bubble(db_b),
        .ctrl_o_regE_stall(es_b), .ctrl_o_regE_bubble(eb_b), .ctrl_o_regM_bubble(mb_b),
        .ctrl_o_stall_cnt(scnt_b), .ctrl_o_flush_cnt(fcnt_b)
    );

    // ctrl bit order: {F stall, D stall, D bubble, E stall, E bubble, M bubble}
    typedef struct {
        logic [5:0] ca;
        logic [5:0] cb;
        longint     sa;
        longint     fa;
        longint     sb;
        longint     fb;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     txn = 0;
    logic   rst_drive;

    // Model state: remaining D-bubble cycles of a flush window, and counter values.
    int     rem_m[2];
    longint sc_m[2];
    longint fc_m[2];
    int     flush_par[2] = '{2, 1};
    longint max_m[2]     = '{64'hFFFF_FFFF, 64'd15};

    function automatic longint sat_inc(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic jmp, input logic bsy);
        logic       hz;
        logic [5:0] c[2];
        longint     es[2];
        longint     ef[2];
        exp_t       e;
        @(posedge clk);
        #1;
        rst = rst_drive;
        rs1 = r1; rs2 = r2; rs1_used = u1; rs2_used = u2;
        wb_rd = rd; wb_wen = wen; is_load = ld; need_jump = jmp; busy = bsy;
        hz = ld && wen && (rd != 5'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        for (int d = 0; d < 2; d++) begin
            if (!rst_drive) begin
                rem_m[d] = 0; sc_m[d] = 0; fc_m[d] = 0;
                c[d] = 6'b000000; es[d] = 0; ef[d] = 0;
            end else begin
                es[d] = sc_m[d];
                ef[d] = fc_m[d];
                if (bsy) begin
                    c[d] = 6'b110101;
                    sc_m[d] = sat_inc(sc_m[d], max_m[d]);
                end else if (jmp) begin
                    c[d] = 6'b001010;
                    rem_m[d] = flush_par[d] - 1;
                    fc_m[d] = sat_inc(fc_m[d], max_m[d]);
                end else if (rem_m[d] > 0) begin
                    c[d] = 6'b001000;
                    rem_m[d]--;
                end else if (hz) begin
                    c[d] = 6'b110010;
                    sc_m[d] = sat_inc(sc_m[d], max_m[d]);
                end else begin
                    c[d] = 6'b000000;
                end
            end
        end
        e.ca = c[0]; e.cb = c[1];
        e.sa = es[0]; e.fa = ef[0]; e.sb = es[1]; e.fb = ef[1];
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic void chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn=%0d: got %0h, expected %0h", name, txn, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ctrl_a", longint'({fs_a, ds_a, db_a, es_a, eb_a, mb_a}), longint'(e.ca));
            chk("ctrl_b", longint'({fs_b, ds_b, db_b, es_b, eb_b, mb_b}), longint'(e.cb));
            chk("stall_cnt_a", longint'(scnt_a), e.sa);
            chk("flush_cnt_a", longint'(fcnt_a), e.fa);
            chk("stall_cnt_b", longint'(scnt_b), e.sb);
            chk("flush_cnt_b", longint'(fcnt_b), e.fb);
            $display("txn %0d ctrl_a=%b ctrl_b=%b stall_a=%0d flush_a=%0d stall_b=%0d flush_b=%0d",
                     txn, {fs_a, ds_a, db_a, es_a, eb_a, mb_a}, {fs_b, ds_b, db_b, es_b, eb_b, mb_b},
                     scnt_a, fcnt_a, scnt_b, fcnt_b);
            txn++;
        end
    end

    initial begin
        rst = 1'b0; rst_drive = 1'b0;
        rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        wb_rd = '0; wb_wen = 1'b0; is_load = 1'b0; need_jump = 1'b0; busy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rem_m[d] = 0; sc_m[d] = 0; fc_m[d] = 0;
        end

        idle(); idle();
        rst_drive = 1'b1;
        idle();

        // load-use on rs2 = x5, then E drains
        step(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(); idle();
        // x0 destination, and non-writing load with matching rd
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        // redirect window
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(); idle();
        // busy freezes an open flush window
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        // redirect beats load-use; busy beats redirect
        step(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        step(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(); idle();
        // held load-use drives the 4-bit stall counter into saturation
        repeat (20) step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        // reset in the middle of a flush window
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_drive = 1'b0;
        step(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        rst_drive = 1'b1;
        idle(); idle();

        for (int i = 0; i < 300; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 5) == 0));
        end
        idle();

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
